// File: rtl/gf180mcu_fd_sc_mcu9t5v0__scan_capture_chain_pkg.sv
// ---------------------------------------------------------------------------
// gf180mcu_fd_sc_mcu9t5v0__scan_capture_chain_pkg
//
// Purpose:
//   Shared definitions for the scan-capture chain.
//   - State encoding for the capture/shift controller. It is 2 bits wide, and IDLE is 0.
//   - A small helper that decodes the BUSY condition from a state value.
//
// Ports: none (package).
// ---------------------------------------------------------------------------
package gf180mcu_fd_sc_mcu9t5v0__scan_capture_chain_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_SHIFT   = 2'd2,
        ST_DONE    = 2'd3
    } state_e;

    // BUSY covers every state except IDLE, DONE included.
    function automatic logic is_busy(input state_e s);
        return s != ST_IDLE;
    endfunction

endpackage

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__scan_capture_chain_func.sv
// ---------------------------------------------------------------------------
// gf180mcu_fd_sc_mcu9t5v0__scan_capture_chain_func
//
// Purpose:
//   Behavioural core of the scan-capture chain. This module holds the capture
//   register, the shift counter and the START-driven controller.
//   - In IDLE the register acts as a plain flop bank (SE=0) or as a serial
//     shift chain (SE=1).
//   - A START pulse in IDLE runs one full sequence:
//     capture D once, shift WIDTH bits, then pulse DONE for one cycle.
//
// Ports:
//   clk    in   rising-edge clock
//   rst_n  in   asynchronous active-low reset
//   d      in   [WIDTH-1:0] functional capture data
//   se     in   scan enable; only honoured in IDLE
//   si     in   scan serial input; shifts into q[0]
//   start  in   start one capture+shift sequence; only sampled in IDLE
//   q      out  [WIDTH-1:0] register contents
//   so     out  scan serial output, equal to q[WIDTH-1]
//   busy   out  high whenever the controller is not in IDLE
//   done   out  registered one-cycle end-of-sequence pulse
//   VDD/VSS inout, present only under USE_POWER_PINS
// ---------------------------------------------------------------------------
module gf180mcu_fd_sc_mcu9t5v0__scan_capture_chain_func
    import gf180mcu_fd_sc_mcu9t5v0__scan_capture_chain_pkg::*;
#(
    parameter  int WIDTH = 4,
    localparam int CNT_W = $clog2(WIDTH)
) (
`ifdef USE_POWER_PINS
    inout  wire              VDD,
    inout  wire              VSS,
`endif
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    input  logic             se,
    input  logic             si,
    input  logic             start,
    output logic [WIDTH-1:0] q,
    output logic             so,
    output logic             busy,
    output logic             done
);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   q_q, q_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               done_q, done_d;
    logic [WIDTH-1:0]   shifted;

    assign shifted = {q_q[WIDTH-2:0], si};

    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // Ternaries are used here so that an X on se or start
                // propagates into the affected bits instead of being masked.
                q_d     = se ? shifted : d;
                state_d = start ? ST_CAPTURE : ST_IDLE;
            end
            ST_CAPTURE: begin
                q_d     = d;
                cnt_d   = '0;
                state_d = ST_SHIFT;
            end
            ST_SHIFT: begin
                q_d = shifted;
                // The counter holds on the final shift rather than wrapping.
                // A fresh CAPTURE clears it again before the next sequence.
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DONE: begin
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = state_q;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            q_q     <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    assign q    = q_q;
    assign so   = q_q[WIDTH-1];
    assign busy = is_busy(state_q);
    assign done = done_q;

endmodule

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__scan_capture_chain.sv
// ---------------------------------------------------------------------------
// gf180mcu_fd_sc_mcu9t5v0__scan_capture_chain
//
// Purpose:
//   Cell-level wrapper around the scan-capture core. It sits directly
//   downstream of the combinational cell under test. The wrapper:
//   - forwards the power pins when USE_POWER_PINS is defined;
//   - adds the timing arcs and timing checks for gate-level simulation.
//
// Ports:
//   CLK    in   rising-edge clock
//   RN     in   asynchronous active-low reset
//   D      in   [WIDTH-1:0] functional capture data
//   SE     in   scan enable (IDLE only)
//   SI     in   scan serial input
//   START  in   request one capture+shift sequence (IDLE only)
//   Q      out  [WIDTH-1:0] register contents
//   SO     out  scan serial output = Q[WIDTH-1]
//   BUSY   out  controller not in IDLE
//   DONE   out  one-cycle end-of-sequence pulse
//   VDD/VSS inout, present only under USE_POWER_PINS
// ---------------------------------------------------------------------------
module gf180mcu_fd_sc_mcu9t5v0__scan_capture_chain
    import gf180mcu_fd_sc_mcu9t5v0__scan_capture_chain_pkg::*;
#(
    parameter int WIDTH = 4
) (
`ifdef USE_POWER_PINS
    inout  wire              VDD,
    inout  wire              VSS,
`endif
    input  logic             CLK,
    input  logic             RN,
    input  logic [WIDTH-1:0] D,
    input  logic             SE,
    input  logic             SI,
    input  logic             START,
    output logic [WIDTH-1:0] Q,
    output logic             SO,
    output logic             BUSY,
    output logic             DONE
);

    gf180mcu_fd_sc_mcu9t5v0__scan_capture_chain_func #(
        .WIDTH (WIDTH)
    ) u_func (
`ifdef USE_POWER_PINS
        .VDD   (VDD),
        .VSS   (VSS),
`endif
        .clk   (CLK),
        .rst_n (RN),
        .d     (D),
        .se    (SE),
        .si    (SI),
        .start (START),
        .q     (Q),
        .so    (SO),
        .busy  (BUSY),
        .done  (DONE)
    );

`ifndef FUNCTIONAL
    // All timing checks share one notifier.
    reg notifier;

    specify
        (CLK *> Q)  = (1.0, 1.0);
        (CLK => SO) = (1.0, 1.0);
        (RN  *> Q)  = (1.0, 1.0);
        $setuphold(posedge CLK, D,     1.0, 1.0, notifier);
        $setuphold(posedge CLK, SI,    1.0, 1.0, notifier);
        $setuphold(posedge CLK, SE,    1.0, 1.0, notifier);
        $setuphold(posedge CLK, START, 1.0, 1.0, notifier);
        $recrem(posedge RN, posedge CLK, 1.0, 1.0, notifier);
        $width(posedge CLK, 1.0, 0, notifier);
        $width(negedge CLK, 1.0, 0, notifier);
        $width(negedge RN,  1.0, 0, notifier);
    endspecify
`endif

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu9t5v0__scan_capture_chain.sv
// ---------------------------------------------------------------------------
// tb_gf180mcu_fd_sc_mcu9t5v0__scan_capture_chain
//
// Directed bench for the scan-capture chain at WIDTH=4.
// - Each step drives the inputs and pushes the expected Q/BUSY/DONE onto a
//   scoreboard. The expected SO is derived from the expected Q[3].
// - After the rising edge the bench pops the entry and compares it against
//   the DUT, sampling 1 time unit after the edge.
// ---------------------------------------------------------------------------
module tb_gf180mcu_fd_sc_mcu9t5v0__scan_capture_chain;

    logic       CLK;
    logic       RN;
    logic [3:0] D;
    logic       SE;
    logic       SI;
    logic       START;
    logic [3:0] Q;
    logic       SO;
    logic       BUSY;
    logic       DONE;

    typedef struct {
        string      tag;
        logic [3:0] q;
        logic       so;
        logic       busy;
        logic       done;
    } expT;

    expT scoreboard[$];
    int  compared   = 0;
    int  mismatched = 0;

    gf180mcu_fd_sc_mcu9t5v0__scan_capture_chain #(
        .WIDTH (4)
    ) dut (
        .CLK   (CLK),
        .RN    (RN),
        .D     (D),
        .SE    (SE),
        .SI    (SI),
        .START (START),
        .Q     (Q),
        .SO    (SO),
        .BUSY  (BUSY),
        .DONE  (DONE)
    );

    // Free-running clock with a period of 10 time units.
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Watchdog that guarantees the run always ends.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    // Drive all functional inputs at once.
    task automatic applyStimulus(input logic [3:0] d, input logic se,
                                 input logic si, input logic start);
        D     = d;
        SE    = se;
        SI    = si;
        START = start;
    endtask

    // Push an expectation; SO always mirrors the top bit of Q.
    task automatic expectOut(input string tag, input logic [3:0] q,
                             input logic busy, input logic done);
        expT e;
        e.tag  = tag;
        e.q    = q;
        e.so   = q[3];
        e.busy = busy;
        e.done = done;
        scoreboard.push_back(e);
    endtask

    // Pop the oldest expectation and compare it against the live outputs.
    task automatic checkOutput();
        expT e;
        compared++;
        if (scoreboard.size() == 0) begin
            mismatched++;
            $display("[TB] FAIL scoreboard_empty: observed no entry, expected one");
            return;
        end
        e = scoreboard.pop_front();
        assert ({Q, SO, BUSY, DONE} === {e.q, e.so, e.busy, e.done})
        else begin
            mismatched++;
            $error("[TB] FAIL %s: observed Q=%b SO=%b BUSY=%b DONE=%b, expected Q=%b SO=%b BUSY=%b DONE=%b",
                   e.tag, Q, SO, BUSY, DONE, e.q, e.so, e.busy, e.done);
        end
    endtask

    // Queue an expectation, take one rising edge, then compare.
    task automatic stepClock(input string tag, input logic [3:0] q,
                             input logic busy, input logic done);
        expectOut(tag, q, busy, done);
        @(posedge CLK);
        #1;
        checkOutput();
    endtask

    initial begin
        logic [3:0] loopQ;
        int         phase;

        // Asynchronous reset, checked before any clock edge.
        RN = 1'b1;
        applyStimulus(4'b0000, 1'b0, 1'b0, 1'b0);
        #1 RN = 1'b0;
        #1;
        expectOut("reset_async", 4'b0000, 1'b0, 1'b0);
        checkOutput();
        applyStimulus(4'b1111, 1'b0, 1'b0, 1'b1);
        stepClock("reset_hold", 4'b0000, 1'b0, 1'b0);
        RN = 1'b1;

        // Normal mode: plain flop bank.
        applyStimulus(4'b0110, 1'b0, 1'b0, 1'b0);
        stepClock("normal_0110", 4'b0110, 1'b0, 1'b0);
        applyStimulus(4'b1001, 1'b0, 1'b0, 1'b0);
        stepClock("normal_1001", 4'b1001, 1'b0, 1'b0);

        // Full sequence: capture 1010, then shift in four 1s.
        applyStimulus(4'b1010, 1'b0, 1'b1, 1'b1);
        stepClock("seq_start",   4'b1010, 1'b1, 1'b0);
        applyStimulus(4'b1010, 1'b0, 1'b1, 1'b0);
        stepClock("seq_capture", 4'b1010, 1'b1, 1'b0);
        applyStimulus(4'b0000, 1'b0, 1'b1, 1'b0);
        stepClock("seq_shift1",  4'b0101, 1'b1, 1'b0);
        stepClock("seq_shift2",  4'b1011, 1'b1, 1'b0);
        stepClock("seq_shift3",  4'b0111, 1'b1, 1'b0);
        stepClock("seq_shift4",  4'b1111, 1'b1, 1'b0);
        stepClock("seq_done",    4'b1111, 1'b0, 1'b1);
        stepClock("seq_idle",    4'b0000, 1'b0, 1'b0);

        // START and SE held high while busy must be ignored.
        applyStimulus(4'b0011, 1'b0, 1'b0, 1'b1);
        stepClock("busy_start",   4'b0011, 1'b1, 1'b0);
        applyStimulus(4'b0011, 1'b1, 1'b0, 1'b1);
        stepClock("busy_capture", 4'b0011, 1'b1, 1'b0);
        stepClock("busy_shift1",  4'b0110, 1'b1, 1'b0);
        stepClock("busy_shift2",  4'b1100, 1'b1, 1'b0);
        stepClock("busy_shift3",  4'b1000, 1'b1, 1'b0);
        stepClock("busy_shift4",  4'b0000, 1'b1, 1'b0);
        applyStimulus(4'b0101, 1'b0, 1'b0, 1'b0);
        stepClock("busy_done",    4'b0000, 1'b0, 1'b1);
        stepClock("busy_norestart1", 4'b0101, 1'b0, 1'b0);
        stepClock("busy_norestart2", 4'b0101, 1'b0, 1'b0);

        // IDLE scan shifting from an all-zero register.
        applyStimulus(4'b0000, 1'b0, 1'b0, 1'b0);
        stepClock("scan_clear", 4'b0000, 1'b0, 1'b0);
        applyStimulus(4'b0000, 1'b1, 1'b1, 1'b0);
        stepClock("scan_si1",   4'b0001, 1'b0, 1'b0);
        applyStimulus(4'b0000, 1'b1, 1'b1, 1'b0);
        stepClock("scan_si2",   4'b0011, 1'b0, 1'b0);
        applyStimulus(4'b0000, 1'b1, 1'b0, 1'b0);
        stepClock("scan_si3",   4'b0110, 1'b0, 1'b0);
        applyStimulus(4'b0000, 1'b1, 1'b1, 1'b0);
        stepClock("scan_si4",   4'b1101, 1'b0, 1'b0);

        // START held high: back-to-back sequences repeat every 7 cycles.
        applyStimulus(4'b1100, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 14; i++) begin
            phase = i % 7;
            case (phase)
                0, 1:    loopQ = 4'b1100;
                2:       loopQ = 4'b1000;
                default: loopQ = 4'b0000;
            endcase
            stepClock($sformatf("held_start_%0d", i), loopQ,
                      (phase != 6), (phase == 6));
        end
        applyStimulus(4'b1100, 1'b0, 1'b0, 1'b0);
        stepClock("held_release", 4'b1100, 1'b0, 1'b0);

        // Reset asserted mid-SHIFT must clear everything without a clock.
        applyStimulus(4'b1111, 1'b0, 1'b0, 1'b1);
        stepClock("rst_seq_start",   4'b1111, 1'b1, 1'b0);
        applyStimulus(4'b1111, 1'b0, 1'b0, 1'b0);
        stepClock("rst_seq_capture", 4'b1111, 1'b1, 1'b0);
        stepClock("rst_seq_shift1",  4'b1110, 1'b1, 1'b0);
        stepClock("rst_seq_shift2",  4'b1100, 1'b1, 1'b0);
        #2 RN = 1'b0;
        #1;
        expectOut("reset_mid_shift", 4'b0000, 1'b0, 1'b0);
        checkOutput();
        stepClock("reset_mid_hold", 4'b0000, 1'b0, 1'b0);
        RN = 1'b1;
        applyStimulus(4'b0011, 1'b0, 1'b0, 1'b0);
        stepClock("post_reset_idle", 4'b0011, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
